// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the pipeline stall controller.
// Holds the Tuse/Tnew encodings, the default multiply/divide latencies and the busy-tracker state type.
package pipe_pkg;

    typedef logic [1:0] tcode_t;

    localparam tcode_t T_ZERO = 2'd0;
    localparam tcode_t T_ONE  = 2'd1;
    localparam tcode_t T_TWO  = 2'd2;
    localparam tcode_t T_NONE = 2'd3;

    localparam int MULT_LAT_DFLT = 5;
    localparam int DIV_LAT_DFLT  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Counter width able to hold the largest reload value (LAT-1).
    function automatic int lat_width(input int lat_a, input int lat_b);
        int lat_max;
        lat_max = (lat_a > lat_b) ? lat_a : lat_b;
        return (lat_max <= 2) ? 1 : $clog2(lat_max);
    endfunction

    // A producer blocks a source only when it writes a real register
    // that the consumer needs before the result can be forwarded.
    function automatic logic src_hazard(input logic [4:0] a3,
                                        input logic [4:0] src,
                                        input tcode_t     tuse,
                                        input tcode_t     tnew);
        return (a3 != 5'd0) && (a3 == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the stall controller: decode/execute/memory hazard
// fields and multiply/divide issue on the way in, stall and HI/LO status on the way out.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_pkg::*;

    logic [4:0]       D_rs;
    logic [4:0]       D_rt;
    tcode_t           D_tuse_rs;
    tcode_t           D_tuse_rt;
    logic             D_is_md;
    logic [4:0]       E_A3;
    tcode_t           E_tnew;
    logic [4:0]       M_A3;
    tcode_t           M_tnew;
    logic             E_md_start;
    logic             E_md_div;
    logic             stall;
    logic             md_busy;
    logic             md_done;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_div,
        input  stall, md_busy, md_done, md_err, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_div,
        output stall, md_busy, md_done, md_err, stall_cnt
    );

endinterface

// File: rtl/md_busy_tracker.sv
// Tracks the sequential HI/LO unit: how long it stays busy after a mult/div issue,
// the pulse in its last busy cycle, and a sticky flag for starts that arrive too early.
module md_busy_tracker
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DFLT,
    parameter int DIV_LAT  = DIV_LAT_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int CW = lat_width(MULT_LAT, DIV_LAT);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_t     state;
    md_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] load;
    logic          err_nxt;

    assign load = div ? DIV_LOAD : MULT_LOAD;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = load;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                    if (start) begin
                        err_nxt = 1'b1;
                    end
                end else if (start) begin
                    // Final busy cycle can accept the next op back-to-back.
                    cnt_nxt = load;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == BUSY);
            done  <= (state_nxt == BUSY) && (cnt_nxt == '0);
            err   <= err_nxt;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall controller beside the D/E register: Tuse/Tnew hazard checks against E and M,
// HI/LO busy interlock, and a free-running count of stalled cycles.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DFLT,
    parameter int DIV_LAT  = DIV_LAT_DFLT,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);

    logic data_stall;
    logic md_stall;
    logic stall_now;

    always_comb begin
        data_stall = src_hazard(bus.E_A3, bus.D_rs, bus.D_tuse_rs, bus.E_tnew)
                   | src_hazard(bus.E_A3, bus.D_rt, bus.D_tuse_rt, bus.E_tnew)
                   | src_hazard(bus.M_A3, bus.D_rs, bus.D_tuse_rs, bus.M_tnew)
                   | src_hazard(bus.M_A3, bus.D_rt, bus.D_tuse_rt, bus.M_tnew);
    end

    // An op entering E this cycle already occupies the unit for the one in D.
    assign md_stall  = bus.D_is_md & (bus.md_busy | bus.E_md_start);
    assign stall_now = data_stall | md_stall;
    assign bus.stall = stall_now;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_tracker (
        .clk   (clk),
        .reset (reset),
        .start (bus.E_md_start),
        .div   (bus.E_md_div),
        .busy  (bus.md_busy),
        .done  (bus.md_done),
        .err   (bus.md_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.stall_cnt <= '0;
        end else if (stall_now) begin
            bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs queued by the driver and checked by an independent monitor.
module tb_hazard_stall_ctrl;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    typedef struct {
        logic        stall;
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    bit   stim_done;

    exp_t exp_q[$];

    // Reference: remaining busy cycles of the HI/LO unit, including the current one.
    int          rem;
    bit          m_err;
    logic [31:0] m_cnt;

    hazard_stall_ctrl_if #(.CNT_W(32)) bus ();

    hazard_stall_ctrl #(
        .MULT_LAT (MULT),
        .DIV_LAT  (DIV),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit hz(input logic [4:0] a3, input logic [4:0] src,
                              input logic [1:0] tuse, input logic [1:0] tnew);
        return (a3 != 0) && (a3 == src) && (int'(tuse) < int'(tnew));
    endfunction

    function automatic bit ref_stall();
        bit d;
        d = hz(bus.E_A3, bus.D_rs, bus.D_tuse_rs, bus.E_tnew)
          | hz(bus.E_A3, bus.D_rt, bus.D_tuse_rt, bus.E_tnew)
          | hz(bus.M_A3, bus.D_rs, bus.D_tuse_rs, bus.M_tnew)
          | hz(bus.M_A3, bus.D_rt, bus.D_tuse_rt, bus.M_tnew);
        return d | (bus.D_is_md & ((rem > 0) | bus.E_md_start));
    endfunction

    task automatic tick();
        exp_t e;
        bit   s;
        s       = ref_stall();
        e.stall = s;
        e.busy  = (rem > 0);
        e.done  = (rem == 1);
        e.err   = m_err;
        e.cnt   = m_cnt;
        e.cyc   = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            rem   = 0;
            m_err = 0;
            m_cnt = 0;
        end else begin
            if (s) m_cnt = m_cnt + 1;
            if (bus.E_md_start) begin
                if (rem <= 1) rem = bus.E_md_div ? DIV : MULT;
                else begin
                    m_err = 1;
                    rem   = rem - 1;
                end
            end else if (rem > 0) begin
                rem = rem - 1;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        bus.D_rs = 0; bus.D_rt = 0; bus.D_tuse_rs = 3; bus.D_tuse_rt = 3;
        bus.D_is_md = 0; bus.E_A3 = 0; bus.E_tnew = 0; bus.M_A3 = 0; bus.M_tnew = 0;
        bus.E_md_start = 0; bus.E_md_div = 0;
    endtask

    task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("stall",     e.cyc, 32'(bus.stall),   32'(e.stall));
                cmp("md_busy",   e.cyc, 32'(bus.md_busy), 32'(e.busy));
                cmp("md_done",   e.cyc, 32'(bus.md_done), 32'(e.done));
                cmp("md_err",    e.cyc, 32'(bus.md_err),  32'(e.err));
                cmp("stall_cnt", e.cyc, bus.stall_cnt,    e.cnt);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; stim_done = 0;
        rem = 0; m_err = 0; m_cnt = 0;
        reset = 1'b0;
        clear_inputs();
        bus.E_md_start = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset held with a start pending, then release.
        tick(); tick();
        reset = 1'b1;
        bus.E_md_start = 0;
        repeat (3) tick();

        // Load-use from E, then from M, then resolved.
        bus.D_rs = 8; bus.D_tuse_rs = 0; bus.E_A3 = 8; bus.E_tnew = 2;
        tick();
        bus.E_A3 = 0; bus.E_tnew = 0; bus.M_A3 = 8; bus.M_tnew = 1;
        tick();
        bus.M_tnew = 0;
        tick();

        // $0 never stalls; an unused rt never stalls.
        clear_inputs();
        bus.D_rs = 0; bus.D_tuse_rs = 0; bus.E_A3 = 0; bus.E_tnew = 2;
        tick();
        clear_inputs();
        bus.D_rt = 5; bus.D_tuse_rt = 3; bus.E_A3 = 5; bus.E_tnew = 2; bus.M_A3 = 5; bus.M_tnew = 2;
        tick();
        clear_inputs();
        bus.D_rt = 5; bus.D_tuse_rt = 1; bus.M_A3 = 5; bus.M_tnew = 2;
        tick();
        clear_inputs();

        // Multiply with a dependent HI/LO access waiting in D.
        bus.D_is_md = 1; bus.E_md_start = 1; bus.E_md_div = 0;
        tick();
        bus.E_md_start = 0;
        repeat (6) tick();
        bus.D_is_md = 0;
        repeat (2) tick();

        // Divide, back-to-back restart on the last busy edge, then an early start.
        bus.E_md_start = 1; bus.E_md_div = 1;
        tick();
        bus.E_md_start = 0;
        repeat (9) tick();
        bus.E_md_start = 1;
        tick();
        bus.E_md_start = 0;
        repeat (4) tick();
        bus.E_md_start = 1; bus.E_md_div = 0;
        tick();
        bus.E_md_start = 0;
        repeat (8) tick();

        // Reset in the fourth busy cycle of a divide.
        bus.E_md_start = 1; bus.E_md_div = 1;
        tick();
        bus.E_md_start = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (12) tick();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.D_rs       = 5'($urandom_range(0, 3));
            bus.D_rt       = 5'($urandom_range(0, 3));
            bus.D_tuse_rs  = 2'($urandom_range(0, 3));
            bus.D_tuse_rt  = 2'($urandom_range(0, 3));
            bus.D_is_md    = ($urandom_range(0, 3) == 0);
            bus.E_A3       = 5'($urandom_range(0, 3));
            bus.E_tnew     = 2'($urandom_range(0, 3));
            bus.M_A3       = 5'($urandom_range(0, 3));
            bus.M_tnew     = 2'($urandom_range(0, 3));
            bus.E_md_start = ($urandom_range(0, 7) == 0);
            bus.E_md_div   = 1'($urandom_range(0, 1));
            reset          = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;
        clear_inputs();
        stim_done = 1;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall controller for the 5-stage MIPS pipeline; sits beside the D/E pipeline register.
- Combines data-hazard detection (Tuse/Tnew against E and M stages) with a sequential multiply/divide busy tracker.
- Produces one `stall`:
  - freezes PC and the F/D register;
  - drives the D/E register's stall input, which inserts a bubble into E and keeps PC4/PC8.
- Also keeps a stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu after issue from E
- DIV_LAT, 10, busy cycles for div/divu after issue from E
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- D_rs  in  5  rs field of the instruction in D
- D_rt  in  5  rt field of the instruction in D
- D_tuse_rs  in  2  cycles until D needs rs (3 = never used)
- D_tuse_rt  in  2  cycles until D needs rt (3 = never used)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register of the instruction in E
- E_tnew  in  2  cycles until the E result is forwardable
- M_A3  in  5  destination register of the instruction in M
- M_tnew  in  2  cycles until the M result is forwardable
- E_md_start  in  1  mult/div is in E this cycle
- E_md_div  in  1  1 = divide, 0 = multiply; qualified by E_md_start
- stall  out  1  freeze PC/FD, bubble DE
- md_busy  out  1  HI/LO unit busy
- md_done  out  1  one-cycle pulse in the final busy cycle
- md_err  out  1  sticky: start seen while busy
- stall_cnt  out  CNT_W  number of cycles with stall=1

Behaviour:
- Reset, taken when reset=0 at a clk edge:
  - state=IDLE, busy counter=0;
  - md_busy=0, md_done=0, md_err=0, stall_cnt=0.
  - Reset during BUSY aborts the operation; no md_done is produced.
- data_stall is combinational. It is 1 when any of these holds:
  - E_A3≠0 && E_A3==D_rs && D_tuse_rs<E_tnew
  - E_A3≠0 && E_A3==D_rt && D_tuse_rt<E_tnew
  - M_A3≠0 && M_A3==D_rs && D_tuse_rs<M_tnew
  - M_A3≠0 && M_A3==D_rt && D_tuse_rt<M_tnew
  - Register 0 never causes a stall.
- md_stall is combinational: D_is_md && (md_busy || E_md_start).
- stall = data_stall | md_stall. It is combinational and is valid in the same cycle its inputs are valid.
- MD FSM, states IDLE and BUSY:
  - IDLE, E_md_start=1 at an edge: go to BUSY; cnt = (E_md_div ? DIV_LAT : MULT_LAT) − 1.
  - BUSY, cnt≠0: cnt decrements each edge.
  - BUSY, cnt==0: go to IDLE at the next edge.
  - md_busy=1 exactly while in BUSY, i.e. for LAT consecutive cycles starting the cycle after the start edge.
  - md_done = (state==BUSY && cnt==0), registered-state derived, so a 1-cycle pulse.
  - E_md_start=1 while BUSY is ignored: the FSM is unchanged and md_err is set until reset.
  - The same edge that returns BUSY→IDLE may also accept a new E_md_start; it reloads cnt and stays in BUSY. md_busy stays high with no gap.
- stall_cnt increments on each edge where stall=1 and reset=1. It wraps modulo 2^CNT_W.
- Latency: stall has zero cycles of latency from its inputs. The FSM has a 1-cycle latency from E_md_start to md_busy.

Decomposition:
- Shared package `pipe_pkg`:
  - TUSE/TNEW encodings (0..2, 3 = none);
  - MULT_LAT and DIV_LAT constants;
  - FSM state encoding (IDLE=0, BUSY=1).
- One natural sub-module, `md_busy_tracker`: FSM, counter, md_done and md_err.
- The top level holds the hazard comparators, the stall OR and stall_cnt.

Test Plan:
- Reset: hold reset=0 for 2 cycles with E_md_start=1 → md_busy=0, stall_cnt=0, md_err=0. Release → all remain 0.
- Load-use: D_rs=8, D_tuse_rs=0, E_A3=8, E_tnew=2 → stall=1. Next cycle M_A3=8, M_tnew=1 → stall=1. Then M_tnew=0 → stall=0. stall_cnt=2.
- $0 and no-hazard checks:
  - E_A3=0, D_rs=0, D_tuse_rs=0, E_tnew=2 → stall=0.
  - D_tuse_rt=3 with an rt match → stall=0.
- Multiply: E_md_start=1, E_md_div=0 at edge t → md_busy=1 for cycles t+1..t+5, md_done=1 only in t+5. D_is_md=1 during that window → stall=1 in cycle t and cycles t+1..t+5.
- Divide with back-to-back start and error:
  - div start → 10 busy cycles.
  - Start asserted on the final busy edge → md_busy continuous for 20 cycles total.
  - Start mid-busy → md_err=1, sticky.
- Reset mid-divide: reset=0 at busy cycle 4 → md_busy=0 next cycle, no md_done pulse.
